// File: rtl/wb_timer_mc.sv
// Multi-channel Wishbone machine timer: shared 64-bit prescaled time base feeding
// NUM_CH compare channels with one-shot or auto-reload mode and sticky, maskable irqs.
module wb_timer_mc #(
  parameter int NUM_CH  = 4,
  parameter int PRESC_W = 16,
  parameter int ADDR_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wb_cyc_i,
  input  logic              wb_stb_i,
  input  logic              wb_we_i,
  input  logic [ADDR_W-1:0] wb_adr_i,
  input  logic [3:0]        wb_sel_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  output logic              wb_ack_o,
  output logic              wb_err_o,
  output logic              wb_stall_o,
  output logic [NUM_CH-1:0] irq_o,
  output logic              timer_irq_o
);

  localparam int CHW = ADDR_W - 4;

  logic               ctrl_en_q;
  logic [PRESC_W-1:0] presc_q, pcnt_q;
  logic [63:0]        mtime_q;
  logic [31:0]        shadow_q;
  logic [NUM_CH-1:0]  status_q, irq_en_q, ch_en_q;
  logic [63:0]        cmp_q    [NUM_CH];
  logic [31:0]        period_q [NUM_CH];
  logic               ack_q, err_q;
  logic [31:0]        dat_q;

  logic               access, wr, rd, tick;
  logic [31:0]        bmask, rdata;
  logic [CHW-1:0]     ch_blk, ch_off;
  logic [1:0]         reg_sel;
  logic               valid, hit_ch;
  logic               sel_ctrl, sel_presc, sel_mlo, sel_mhi, sel_status, sel_irqen;
  logic [NUM_CH-1:0]  match, w1c;
  logic               unused_adr;

  function automatic logic [31:0] merge32(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  assign access     = wb_cyc_i & wb_stb_i;
  assign bmask      = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
  assign ch_blk     = wb_adr_i[ADDR_W-1:4];
  assign ch_off     = ch_blk - CHW'(2);
  assign reg_sel    = wb_adr_i[3:2];
  assign unused_adr = ^wb_adr_i[1:0];
  assign wr         = access & valid & wb_we_i;
  assign rd         = access & valid & ~wb_we_i;
  assign tick       = ctrl_en_q && (pcnt_q == presc_q);
  assign w1c        = (wr && sel_status) ? (wb_dat_i[NUM_CH-1:0] & bmask[NUM_CH-1:0]) : '0;

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      match[c] = ch_en_q[c] & (mtime_q >= cmp_q[c]);
    end
  end

  // Address decode and read mux; block 0/1 are global registers, blocks 2.. are channels.
  always_comb begin
    sel_ctrl   = 1'b0;
    sel_presc  = 1'b0;
    sel_mlo    = 1'b0;
    sel_mhi    = 1'b0;
    sel_status = 1'b0;
    sel_irqen  = 1'b0;
    hit_ch     = 1'b0;
    valid      = 1'b0;
    rdata      = '0;
    if (ch_blk == '0) begin
      valid = 1'b1;
      case (reg_sel)
        2'd0:    begin sel_ctrl  = 1'b1; rdata = {31'b0, ctrl_en_q}; end
        2'd1:    begin sel_presc = 1'b1; rdata = 32'(presc_q); end
        2'd2:    begin sel_mlo   = 1'b1; rdata = mtime_q[31:0]; end
        default: begin sel_mhi   = 1'b1; rdata = shadow_q; end
      endcase
    end else if (ch_blk == CHW'(1)) begin
      case (reg_sel)
        2'd0:    begin valid = 1'b1; sel_status = 1'b1; rdata = 32'(status_q); end
        2'd1:    begin valid = 1'b1; sel_irqen  = 1'b1; rdata = 32'(irq_en_q); end
        default: ;
      endcase
    end else if (ch_off < CHW'(NUM_CH)) begin
      valid  = 1'b1;
      hit_ch = 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (ch_off == CHW'(c)) begin
          case (reg_sel)
            2'd0:    rdata = cmp_q[c][31:0];
            2'd1:    rdata = cmp_q[c][63:32];
            2'd2:    rdata = period_q[c];
            default: rdata = {31'b0, ch_en_q[c]};
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_en_q <= 1'b0;
      presc_q   <= '0;
      pcnt_q    <= '0;
      mtime_q   <= '0;
      shadow_q  <= '0;
      status_q  <= '0;
      irq_en_q  <= '0;
      ch_en_q   <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      dat_q     <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        cmp_q[c]    <= '0;
        period_q[c] <= '0;
      end
    end else begin
      ack_q <= access & valid;
      err_q <= access & ~valid;
      dat_q <= rd ? rdata : 32'b0;

      if (wr && sel_ctrl)  ctrl_en_q <= (ctrl_en_q & ~bmask[0]) | (wb_dat_i[0] & bmask[0]);
      if (wr && sel_presc) presc_q <= (presc_q & ~bmask[PRESC_W-1:0]) |
                                      (wb_dat_i[PRESC_W-1:0] & bmask[PRESC_W-1:0]);
      if (wr && sel_irqen) irq_en_q <= (irq_en_q & ~bmask[NUM_CH-1:0]) |
                                       (wb_dat_i[NUM_CH-1:0] & bmask[NUM_CH-1:0]);
      if (rd && sel_mlo)   shadow_q <= mtime_q[63:32];

      // A software write to either MTIME half takes priority over a same-cycle tick.
      if (wr && sel_mlo) begin
        mtime_q[31:0] <= merge32(mtime_q[31:0], wb_dat_i, bmask);
        pcnt_q        <= '0;
      end else if (wr && sel_mhi) begin
        mtime_q[63:32] <= merge32(mtime_q[63:32], wb_dat_i, bmask);
        pcnt_q         <= '0;
      end else if (tick) begin
        mtime_q <= mtime_q + 64'd1;
        pcnt_q  <= '0;
      end else if (ctrl_en_q) begin
        pcnt_q <= pcnt_q + PRESC_W'(1);
      end

      status_q <= (status_q & ~w1c) | match;

      for (int c = 0; c < NUM_CH; c++) begin
        if (wr && hit_ch && ch_off == CHW'(c) && reg_sel == 2'd0) begin
          cmp_q[c][31:0] <= merge32(cmp_q[c][31:0], wb_dat_i, bmask);
        end else if (wr && hit_ch && ch_off == CHW'(c) && reg_sel == 2'd1) begin
          cmp_q[c][63:32] <= merge32(cmp_q[c][63:32], wb_dat_i, bmask);
        end else if (match[c] && period_q[c] != '0) begin
          cmp_q[c] <= cmp_q[c] + 64'(period_q[c]);
        end

        if (wr && hit_ch && ch_off == CHW'(c) && reg_sel == 2'd2) begin
          period_q[c] <= merge32(period_q[c], wb_dat_i, bmask);
        end

        if (wr && hit_ch && ch_off == CHW'(c) && reg_sel == 2'd3) begin
          ch_en_q[c] <= (ch_en_q[c] & ~bmask[0]) | (wb_dat_i[0] & bmask[0]);
        end else if (match[c] && period_q[c] == '0) begin
          ch_en_q[c] <= 1'b0;
        end
      end
    end
  end

  assign wb_dat_o    = dat_q;
  assign wb_ack_o    = ack_q;
  assign wb_err_o    = err_q;
  assign wb_stall_o  = 1'b0;
  assign irq_o       = status_q & irq_en_q;
  assign timer_irq_o = |irq_o;

endmodule

// File: tb/tb_wb_timer_mc.sv
// Directed bench for wb_timer_mc: prescaler, compare modes, MTIME shadow, conflicts, decode errors.
module tb_wb_timer_mc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        wb_cyc_i, wb_stb_i, wb_we_i;
  logic [7:0]  wb_adr_i;
  logic [3:0]  wb_sel_i;
  logic [31:0] wb_dat_i, wb_dat_o;
  logic        wb_ack_o, wb_err_o, wb_stall_o;
  logic [3:0]  irq_o;
  logic        timer_irq_o;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] rdat;
  logic        ack, err;

  always #5 clk_i = ~clk_i;

  wb_timer_mc #(.NUM_CH(4), .PRESC_W(16), .ADDR_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
    .wb_stall_o(wb_stall_o), .irq_o(irq_o), .timer_irq_o(timer_irq_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Called at a negedge; the access edge is the next posedge, response sampled at the next negedge.
  task automatic xfer(input logic we, input logic [7:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, output logic [31:0] d, output logic a, output logic e);
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr; wb_sel_i = sel; wb_dat_i = dat;
    @(negedge clk_i);
    d = wb_dat_o; a = wb_ack_o; e = wb_err_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wr(input logic [7:0] adr, input logic [31:0] dat, input logic [3:0] sel = 4'hF);
    logic [31:0] d; logic a, e;
    xfer(1'b1, adr, dat, sel, d, a, e);
    chk("wr_ack_err", {62'b0, a, e}, 64'b10);
  endtask

  task automatic rd(input logic [7:0] adr, output logic [31:0] d);
    logic a, e;
    xfer(1'b0, adr, 32'h0, 4'hF, d, a, e);
    chk("rd_ack_err", {62'b0, a, e}, 64'b10);
  endtask

  initial begin
    rst_i = 1'b1; wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    wb_adr_i = '0; wb_sel_i = '0; wb_dat_i = '0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;

    chk("rst_ack", {63'b0, wb_ack_o}, 64'd0);
    chk("rst_err", {63'b0, wb_err_o}, 64'd0);
    chk("rst_dat", {32'b0, wb_dat_o}, 64'd0);
    chk("rst_irq", {59'b0, timer_irq_o, irq_o}, 64'd0);
    chk("rst_stall", {63'b0, wb_stall_o}, 64'd0);
    rd(8'h00, rdat); chk("rst_ctrl", {32'b0, rdat}, 64'd0);
    rd(8'h04, rdat); chk("rst_presc", {32'b0, rdat}, 64'd0);
    rd(8'h08, rdat); chk("rst_mtime_lo", {32'b0, rdat}, 64'd0);
    rd(8'h2C, rdat); chk("rst_chctrl0", {32'b0, rdat}, 64'd0);

    // 1: prescaler 3, 40 enabled cycles -> 10 ticks, then hold
    wr(8'h04, 32'd3);
    wr(8'h00, 32'd1);
    repeat (39) @(negedge clk_i);
    wr(8'h00, 32'd0);
    repeat (20) @(negedge clk_i);
    rd(8'h08, rdat); chk("t1_mtime_hold", {32'b0, rdat}, 64'd10);
    rd(8'h04, rdat); chk("t1_presc", {32'b0, rdat}, 64'd3);

    // 2: one-shot channel 0 at MTIME 20
    wr(8'h04, 32'd0);
    wr(8'h08, 32'd0);
    wr(8'h0C, 32'd0);
    wr(8'h20, 32'd20);
    wr(8'h2C, 32'd1);
    wr(8'h14, 32'd1);
    wr(8'h00, 32'd1);
    repeat (20) @(negedge clk_i);
    chk("t2_irq_before", {60'b0, irq_o}, 64'h0);
    @(negedge clk_i);
    chk("t2_irq_rise", {60'b0, irq_o}, 64'h1);
    chk("t2_timer_irq", {63'b0, timer_irq_o}, 64'd1);
    rd(8'h2C, rdat); chk("t2_oneshot_clr", {32'b0, rdat}, 64'd0);
    wr(8'h10, 32'd1);
    chk("t2_w1c_irq", {60'b0, irq_o}, 64'h0);
    wr(8'h00, 32'd0);

    // 3: periodic channel 1, CMP 5 PERIOD 10 -> matches at 5, 15, 25
    wr(8'h08, 32'd0);
    wr(8'h0C, 32'd0);
    wr(8'h30, 32'd5);
    wr(8'h38, 32'd10);
    wr(8'h3C, 32'd1);
    wr(8'h14, 32'd3);
    wr(8'h00, 32'd1);
    repeat (5) @(negedge clk_i);
    chk("t3_irq1_pre5", {63'b0, irq_o[1]}, 64'd0);
    @(negedge clk_i);
    chk("t3_irq1_at5", {63'b0, irq_o[1]}, 64'd1);
    repeat (3) @(negedge clk_i);
    wr(8'h10, 32'd2);
    chk("t3_irq1_clr", {63'b0, irq_o[1]}, 64'd0);
    repeat (5) @(negedge clk_i);
    chk("t3_irq1_pre15", {63'b0, irq_o[1]}, 64'd0);
    @(negedge clk_i);
    chk("t3_irq1_at15", {63'b0, irq_o[1]}, 64'd1);
    repeat (13) @(negedge clk_i);
    wr(8'h00, 32'd0);
    rd(8'h30, rdat); chk("t3_cmp1_lo", {32'b0, rdat}, 64'd35);
    rd(8'h34, rdat); chk("t3_cmp1_hi", {32'b0, rdat}, 64'd0);
    rd(8'h08, rdat); chk("t3_mtime", {32'b0, rdat}, 64'd30);
    wr(8'h3C, 32'd0);
    wr(8'h10, 32'hF);

    // 4: wrap of the 64-bit count and shadowed high half
    wr(8'h08, 32'hFFFF_FFFE);
    wr(8'h0C, 32'hFFFF_FFFF);
    rd(8'h08, rdat); chk("t4_lo_init", {32'b0, rdat}, 64'hFFFF_FFFE);
    rd(8'h0C, rdat); chk("t4_hi_init", {32'b0, rdat}, 64'hFFFF_FFFF);
    wr(8'h00, 32'd1);
    @(negedge clk_i);
    rd(8'h08, rdat); chk("t4_lo_prewrap", {32'b0, rdat}, 64'hFFFF_FFFF);
    rd(8'h0C, rdat); chk("t4_hi_shadow", {32'b0, rdat}, 64'hFFFF_FFFF);
    rd(8'h08, rdat); chk("t4_lo_postwrap", {32'b0, rdat}, 64'd1);
    rd(8'h0C, rdat); chk("t4_hi_postwrap", {32'b0, rdat}, 64'd0);
    wr(8'h00, 32'd0);

    // 5a: W1C of STATUS[0] in the cycle channel 0 matches -> set wins
    wr(8'h10, 32'hF);
    wr(8'h08, 32'd0);
    wr(8'h0C, 32'd0);
    wr(8'h20, 32'd3);
    wr(8'h2C, 32'd1);
    wr(8'h00, 32'd1);
    repeat (3) @(negedge clk_i);
    wr(8'h10, 32'd1);
    rd(8'h10, rdat); chk("t5_set_wins", {32'b0, rdat}, 64'h1);
    rd(8'h2C, rdat); chk("t5_ch0_oneshot", {32'b0, rdat}, 64'd0);
    wr(8'h00, 32'd0);

    // 5b: software CMP write in the reload cycle of channel 2 is kept
    wr(8'h10, 32'hF);
    wr(8'h08, 32'd0);
    wr(8'h0C, 32'd0);
    wr(8'h40, 32'd2);
    wr(8'h48, 32'd7);
    wr(8'h4C, 32'd1);
    wr(8'h00, 32'd1);
    repeat (2) @(negedge clk_i);
    wr(8'h40, 32'd100);
    wr(8'h00, 32'd0);
    rd(8'h40, rdat); chk("t5_sw_cmp_kept", {32'b0, rdat}, 64'd100);
    rd(8'h10, rdat); chk("t5_status2", {32'b0, rdat}, 64'h4);
    wr(8'h4C, 32'd0);
    wr(8'h10, 32'hF);

    // 6: decode errors and byte lanes
    xfer(1'b0, 8'h60, 32'h0, 4'hF, rdat, ack, err);
    chk("t6_rd60_resp", {62'b0, ack, err}, 64'b01);
    chk("t6_rd60_dat", {32'b0, rdat}, 64'd0);
    xfer(1'b0, 8'h18, 32'h0, 4'hF, rdat, ack, err);
    chk("t6_rd18_resp", {62'b0, ack, err}, 64'b01);
    xfer(1'b1, 8'h18, 32'hFFFF_FFFF, 4'hF, rdat, ack, err);
    chk("t6_wr18_resp", {62'b0, ack, err}, 64'b01);
    xfer(1'b1, 8'h1C, 32'hFFFF_FFFF, 4'hF, rdat, ack, err);
    xfer(1'b1, 8'h60, 32'hFFFF_FFFF, 4'hF, rdat, ack, err);
    chk("t6_wr60_resp", {62'b0, ack, err}, 64'b01);
    rd(8'h14, rdat); chk("t6_irqen_kept", {32'b0, rdat}, 64'h3);
    rd(8'h04, rdat); chk("t6_presc_kept", {32'b0, rdat}, 64'd0);
    rd(8'h10, rdat); chk("t6_status_kept", {32'b0, rdat}, 64'd0);
    rd(8'h00, rdat); chk("t6_ctrl_kept", {32'b0, rdat}, 64'd0);
    wr(8'h04, 32'h0000_ABCD);
    wr(8'h04, 32'hFFFF_5A77, 4'b0010);
    rd(8'h04, rdat); chk("t6_byte_lane", {32'b0, rdat}, 64'h5ACD);
    wr(8'h04, 32'hFFFF_FFFF);
    rd(8'h04, rdat); chk("t6_presc_unused", {32'b0, rdat}, 64'hFFFF);
    wr(8'h00, 32'hFFFF_FFFE);
    rd(8'h00, rdat); chk("t6_ctrl_bit0", {32'b0, rdat}, 64'd0);

    // reset during a transfer drops the pending ack and clears state
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 8'h04;
    rst_i = 1'b1;
    @(negedge clk_i);
    chk("rst_mid_ack", {63'b0, wb_ack_o}, 64'd0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    rst_i = 1'b0;
    rd(8'h04, rdat); chk("rst_mid_presc", {32'b0, rdat}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
